// File: rtl/pcie_cpl_tx.sv
// pcie_cpl_tx: completion transmitter for the PCIe slave datapath.
// Accepts one completion request at a time and serialises a 3DW Cpl/CplD TLP
// onto a 32-bit AXI stream. CplD payload is pulled from an FWFT FIFO.
module pcie_cpl_tx (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_en,
    input  logic [15:0] i_completer_id,
    input  logic        i_cpl_req,
    input  logic        i_with_data,
    input  logic [15:0] i_req_id,
    input  logic [7:0]  i_tag,
    input  logic [2:0]  i_tc,
    input  logic [1:0]  i_attr,
    input  logic [6:0]  i_lower_addr,
    input  logic [9:0]  i_length,
    input  logic [2:0]  i_status,
    output logic        o_cpl_busy,
    output logic        o_cpl_done,
    input  logic [31:0] i_data,
    input  logic        i_data_valid,
    output logic        o_data_read,
    output logic [31:0] o_axi_data,
    output logic [3:0]  o_axi_keep,
    output logic        o_axi_last,
    output logic        o_axi_valid,
    input  logic        i_axi_ready
);

    // The state names the beat currently held in the output register.
    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR0,
        S_HDR1,
        S_HDR2,
        S_DATA
    } state_t;

    state_t      state_q, state_d;

    // Request fields captured at acceptance; DW0 is built straight into the
    // output register at that same edge, so only DW1/DW2 fields are kept.
    logic        with_data_q;
    logic [15:0] completer_id_q;
    logic [15:0] req_id_q;
    logic [7:0]  tag_q;
    logic [6:0]  lower_addr_q;
    logic [9:0]  length_q;
    logic [2:0]  status_q;
    logic [10:0] remaining_q;   // payload dwords not yet loaded from the FIFO

    logic        accept;
    logic        start;
    logic        pop;

    assign accept      = o_axi_valid & i_axi_ready;
    assign start       = (state_q == S_IDLE) & i_cpl_req & i_en;
    assign o_axi_keep  = 4'hF;
    assign o_cpl_busy  = (state_q != S_IDLE);
    assign o_data_read = pop;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block ordering.
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state and FIFO pop decision.
    always_comb begin
        // NOTE: defaults first so no path leaves a variable unassigned (latch).
        state_d = state_q;
        pop     = 1'b0;
        unique case (state_q)
            S_IDLE: if (start) state_d = S_HDR0;
            S_HDR0: if (accept) state_d = S_HDR1;
            S_HDR1: if (accept) state_d = S_HDR2;
            S_HDR2: begin
                if (accept) begin
                    if (with_data_q) begin
                        state_d = S_DATA;
                        // First payload word follows DW2 with no bubble.
                        pop     = i_data_valid;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (accept && o_axi_last)
                    state_d = S_IDLE;
                else if ((!o_axi_valid || accept) && remaining_q != 11'd0 && i_data_valid)
                    pop = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Request capture and output beat register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            with_data_q    <= 1'b0;
            completer_id_q <= 16'h0;
            req_id_q       <= 16'h0;
            tag_q          <= 8'h0;
            lower_addr_q   <= 7'h0;
            length_q       <= 10'h0;
            status_q       <= 3'h0;
            remaining_q    <= 11'h0;
            o_axi_data     <= 32'h0;
            o_axi_valid    <= 1'b0;
            o_axi_last     <= 1'b0;
            o_cpl_done     <= 1'b0;
        end else begin
            o_cpl_done <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        with_data_q    <= i_with_data;
                        completer_id_q <= i_completer_id;
                        req_id_q       <= i_req_id;
                        tag_q          <= i_tag;
                        lower_addr_q   <= i_lower_addr;
                        length_q       <= i_length;
                        status_q       <= i_status;
                        remaining_q    <= (i_length == 10'd0) ? 11'd1024 : {1'b0, i_length};
                        o_axi_data     <= {(i_with_data ? 3'b010 : 3'b000), 5'b01010, 1'b0,
                                           i_tc, 6'b0, i_attr, 2'b0,
                                           (i_with_data ? i_length : 10'd0)};
                        o_axi_valid    <= 1'b1;
                        o_axi_last     <= 1'b0;
                    end
                end
                S_HDR0: begin
                    if (accept)
                        o_axi_data <= {completer_id_q, status_q, 1'b0, length_q, 2'b00};
                end
                S_HDR1: begin
                    if (accept) begin
                        o_axi_data <= {req_id_q, tag_q, 1'b0, lower_addr_q};
                        o_axi_last <= !with_data_q;
                    end
                end
                S_HDR2, S_DATA: begin
                    // Beat consumed: register empties unless a pop refills it below.
                    if (accept) begin
                        o_axi_valid <= 1'b0;
                        o_axi_last  <= 1'b0;
                        o_cpl_done  <= o_axi_last;
                    end
                end
                default: ;
            endcase
            if (pop) begin
                o_axi_data  <= i_data;
                o_axi_valid <= 1'b1;
                o_axi_last  <= (remaining_q == 11'd1);
                remaining_q <= remaining_q - 11'd1;
            end
        end
    end

endmodule
